issue_scoreboard: RTL

ID-stage issue controller that schedules instruction hand-off from ID to EXE. It tracks in-flight register writers in a 32-entry scoreboard and holds an instruction in ID while any source operand's producer has not yet made its result bypassable. It drives the ID/EXE valid–allowin handshake and sits between the decoder and the EXE pipeline register, complementing the per-stage bypass network.

---
 rtl/issue_scoreboard_pkg.sv | 15 +
 rtl/issue_scoreboard_sb_entry.sv | 61 ++++++
 rtl/issue_scoreboard.sv | 87 ++++++++
 3 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the ID-stage issue scoreboard.
// Ports: none (package only).
// Default sizes: 32 architectural registers, 2-bit in-flight counters (EXE/MEM/WB).
package issue_scoreboard_pkg;

  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 2;
  localparam int RADDR_W   = 5;

  // Non-zero register test: r0 is hard-wired zero and never tracked.
  function automatic logic reg_nz(input logic [RADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// One scoreboard entry: in-flight writer count plus "newest result not yet bypassable" flag.
// Ports: clk/resetn, flush_i, issue_i + issue_late_i, res_i, retire_i in; late_o out.
// Update priority: flush > issue > RES > retire; single-cycle registered update.
module sb_entry #(
  parameter int CNT_W = issue_scoreboard_pkg::CNT_W_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush_i,
  input  logic issue_i,
  input  logic issue_late_i,
  input  logic res_i,
  input  logic retire_i,
  output logic late_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             late_q, late_d;

  always_comb begin
    cnt_d  = cnt_q;
    late_d = late_q;
    if (flush_i) begin
      cnt_d  = '0;
      late_d = 1'b0;
    end else if (issue_i) begin
      // A retiring older writer and the new writer cancel out in the count;
      // the newly issued writer always defines the late flag.
      if (!retire_i) begin
        cnt_d = cnt_q + 1'b1;
      end
      late_d = issue_late_i;
    end else begin
      if (retire_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
      // With no writer left there is nothing pending; also covers stray
      // retirements after a flush, which saturate at zero.
      if (res_i || (retire_i && (cnt_d == '0))) begin
        late_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      late_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      late_q <= late_d;
    end
  end

  assign late_o = late_q;

  // More than 2^CNT_W-1 writers in flight to one register cannot happen in a legal pipeline.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(issue_i && !retire_i && !flush_i && (cnt_q == {CNT_W{1'b1}})));

endmodule

// File: rtl/issue_scoreboard.sv
// ID-stage issue controller: holds the ID instruction while a source or destination has a late writer.
// Ports: ID decode fields, EXE_allowin, RES/WB events, flush in; ID_ready_go, ID_allowin, ID_to_EXE_valid, stall_cycles out.
// Zero-latency issue; scoreboard updates registered. Macro ISSUE_STALL_CNT_EN builds the stall-cycle counter.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ID_valid,
  input  logic               ID_rf_r_en1,
  input  logic               ID_rf_r_en2,
  input  logic [RADDR_W-1:0] ID_rf_r_addr1,
  input  logic [RADDR_W-1:0] ID_rf_r_addr2,
  input  logic               ID_rf_w_en,
  input  logic [RADDR_W-1:0] ID_rf_w_addr,
  input  logic               ID_late,
  input  logic               EXE_allowin,
  input  logic               RES_valid,
  input  logic [RADDR_W-1:0] RES_addr,
  input  logic               WB_valid,
  input  logic               WB_rf_w_en,
  input  logic [RADDR_W-1:0] WB_rf_w_addr,
  input  logic               flush,
  output logic               ID_ready_go,
  output logic               ID_allowin,
  output logic               ID_to_EXE_valid,
  output logic [31:0]        stall_cycles
);

  logic [NREG-1:0] late;
  logic            src1_ok, src2_ok, waw_ok;
  logic            issue;

  // r0 is never tracked.
  assign late[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    sb_entry #(.CNT_W(CNT_W)) u_ent (
      .clk          (clk),
      .resetn       (resetn),
      .flush_i      (flush),
      .issue_i      (issue && ID_rf_w_en && (ID_rf_w_addr == RADDR_W'(i))),
      .issue_late_i (ID_late),
      .res_i        (RES_valid && (RES_addr == RADDR_W'(i))),
      .retire_i     (WB_valid && WB_rf_w_en && (WB_rf_w_addr == RADDR_W'(i))),
      .late_o       (late[i])
    );
  end

  // Only registered state is read here: a RES/WB event unblocks one cycle later.
  assign src1_ok = !ID_rf_r_en1 || !reg_nz(ID_rf_r_addr1) || !late[ID_rf_r_addr1];
  assign src2_ok = !ID_rf_r_en2 || !reg_nz(ID_rf_r_addr2) || !late[ID_rf_r_addr2];
  // Keeps at most one late writer per register, so one RES clears it.
  assign waw_ok  = !ID_rf_w_en  || !late[ID_rf_w_addr];

  assign ID_ready_go     = src1_ok && src2_ok && waw_ok;
  assign ID_to_EXE_valid = ID_valid && ID_ready_go && !flush;
  assign ID_allowin      = !ID_valid || (ID_ready_go && EXE_allowin);
  assign issue           = ID_to_EXE_valid && EXE_allowin;

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ID_valid && !ID_ready_go) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
